// File: rtl/uparc_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// uparc_lsu_arbiter
//
// Shares one load/store unit (LSU) master port between two requesters:
// instruction fetch (port I) and memory access (port D). Each requester sees
// an LSU-style slave: a one-cycle command, a combinational busy, and read
// data that holds until that port's next read completion.
//
// Each command is captured into a per-port request register. One request at
// a time is granted, replayed on the master port for one cycle, and its
// completion data and error flags are routed back to the owning port.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   i_cmd/i_rnw/i_addr/i_wdata  port I request (cmd 00 IDLE, 01 BYTE,
//                             10 HWORD, 11 WORD; rnw 1 = read)
//   i_rdata, i_busy           port I read data (held), busy/stall
//   i_err_align, i_err_bus    port I one-cycle error pulses
//   d_*                       same set of signals for port D
//   m_cmd/m_rnw/m_addr/m_wdata  master request (registered)
//   m_rdata, m_busy           master read data and busy
//   m_err_align, m_err_bus    master error flags
//
// Configuration
//   UPARC_LSU_ARB_RR_EN  defined: a tie goes to the port not granted last.
//                        undefined: fixed priority, port D wins every tie.
// -----------------------------------------------------------------------------
module uparc_lsu_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [1:0]            i_cmd,
    input  logic                  i_rnw,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_busy,
    output logic                  i_err_align,
    output logic                  i_err_bus,
    input  logic [1:0]            d_cmd,
    input  logic                  d_rnw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_busy,
    output logic                  d_err_align,
    output logic                  d_err_bus,
    output logic [1:0]            m_cmd,
    output logic                  m_rnw,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_busy,
    input  logic                  m_err_align,
    input  logic                  m_err_bus
);

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  pend_i_q, pend_i_d, pend_d_q, pend_d_d;
    logic [1:0]            ireq_cmd_q, ireq_cmd_d, dreq_cmd_q, dreq_cmd_d;
    logic                  ireq_rnw_q, ireq_rnw_d, dreq_rnw_q, dreq_rnw_d;
    logic [ADDR_WIDTH-1:0] ireq_addr_q, ireq_addr_d, dreq_addr_q, dreq_addr_d;
    logic [DATA_WIDTH-1:0] ireq_wdata_q, ireq_wdata_d, dreq_wdata_q, dreq_wdata_d;
    logic [1:0]            m_cmd_q, m_cmd_d;
    logic                  m_rnw_q, m_rnw_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                  i_err_align_q, i_err_align_d, i_err_bus_q, i_err_bus_d;
    logic                  d_err_align_q, d_err_align_d, d_err_bus_q, d_err_bus_d;
    logic                  acc_align_q, acc_align_d, acc_bus_q, acc_bus_d;

    logic                  i_cmd_v, d_cmd_v, cand_i, cand_d;
    logic                  grant_en, tie_winner, winner;
    logic [1:0]            sel_i_cmd, sel_d_cmd;
    logic                  sel_i_rnw, sel_d_rnw;
    logic [ADDR_WIDTH-1:0] sel_i_addr, sel_d_addr;
    logic [DATA_WIDTH-1:0] sel_i_wdata, sel_d_wdata;

    assign i_cmd_v = (i_cmd != CMD_IDLE);
    assign d_cmd_v = (d_cmd != CMD_IDLE);
    assign cand_i  = pend_i_q | i_cmd_v;
    assign cand_d  = pend_d_q | d_cmd_v;
    assign i_busy  = cand_i;
    assign d_busy  = cand_d;

    // A pending port replays its latched request; otherwise the command is
    // arriving this very cycle and is taken straight from the inputs.
    assign sel_i_cmd   = pend_i_q ? ireq_cmd_q   : i_cmd;
    assign sel_i_rnw   = pend_i_q ? ireq_rnw_q   : i_rnw;
    assign sel_i_addr  = pend_i_q ? ireq_addr_q  : i_addr;
    assign sel_i_wdata = pend_i_q ? ireq_wdata_q : i_wdata;
    assign sel_d_cmd   = pend_d_q ? dreq_cmd_q   : d_cmd;
    assign sel_d_rnw   = pend_d_q ? dreq_rnw_q   : d_rnw;
    assign sel_d_addr  = pend_d_q ? dreq_addr_q  : d_addr;
    assign sel_d_wdata = pend_d_q ? dreq_wdata_q : d_wdata;

    assign grant_en = (state_q == ST_IDLE) && (cand_i || cand_d);
    assign winner   = (cand_i && cand_d) ? tie_winner : (cand_d ? OWN_D : OWN_I);

`ifdef UPARC_LSU_ARB_RR_EN
    logic last_q, last_d;

    assign tie_winner = (last_q == OWN_D) ? OWN_I : OWN_D;
    assign last_d     = grant_en ? winner : last_q;

    // Round-robin pointer: remembers the port granted most recently.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_winner = OWN_D;
`endif

    // Next-state logic: request capture, arbitration FSM, master replay,
    // completion routing and error accumulation.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        pend_i_d      = pend_i_q;
        pend_d_d      = pend_d_q;
        ireq_cmd_d    = ireq_cmd_q;
        ireq_rnw_d    = ireq_rnw_q;
        ireq_addr_d   = ireq_addr_q;
        ireq_wdata_d  = ireq_wdata_q;
        dreq_cmd_d    = dreq_cmd_q;
        dreq_rnw_d    = dreq_rnw_q;
        dreq_addr_d   = dreq_addr_q;
        dreq_wdata_d  = dreq_wdata_q;
        m_cmd_d       = CMD_IDLE;
        m_rnw_d       = m_rnw_q;
        m_addr_d      = m_addr_q;
        m_wdata_d     = m_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_err_align_d = 1'b0;
        i_err_bus_d   = 1'b0;
        d_err_align_d = 1'b0;
        d_err_bus_d   = 1'b0;
        acc_align_d   = acc_align_q;
        acc_bus_d     = acc_bus_q;

        // A command on an already-pending port is a protocol violation and
        // is dropped so the pending request is not corrupted.
        if (i_cmd_v && !pend_i_q) begin
            pend_i_d     = 1'b1;
            ireq_cmd_d   = i_cmd;
            ireq_rnw_d   = i_rnw;
            ireq_addr_d  = i_addr;
            ireq_wdata_d = i_wdata;
        end else begin
            pend_i_d     = pend_i_q;
        end

        if (d_cmd_v && !pend_d_q) begin
            pend_d_d     = 1'b1;
            dreq_cmd_d   = d_cmd;
            dreq_rnw_d   = d_rnw;
            dreq_addr_d  = d_addr;
            dreq_wdata_d = d_wdata;
        end else begin
            pend_d_d     = pend_d_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    owner_d = winner;
                    state_d = ST_ISSUE;
                    if (winner == OWN_D) begin
                        m_cmd_d   = sel_d_cmd;
                        m_rnw_d   = sel_d_rnw;
                        m_addr_d  = sel_d_addr;
                        m_wdata_d = sel_d_wdata;
                    end else begin
                        m_cmd_d   = sel_i_cmd;
                        m_rnw_d   = sel_i_rnw;
                        m_addr_d  = sel_i_addr;
                        m_wdata_d = sel_i_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                acc_align_d = acc_align_q | m_err_align;
                acc_bus_d   = acc_bus_q | m_err_bus;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (!m_busy) begin
                    // Completion: errors seen this cycle are folded in here,
                    // the pulse itself appears one cycle later.
                    state_d     = ST_IDLE;
                    acc_align_d = 1'b0;
                    acc_bus_d   = 1'b0;
                    if (owner_q == OWN_D) begin
                        pend_d_d      = 1'b0;
                        d_err_align_d = acc_align_q | m_err_align;
                        d_err_bus_d   = acc_bus_q | m_err_bus;
                        if (m_rnw_q) begin
                            d_rdata_d = m_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        pend_i_d      = 1'b0;
                        i_err_align_d = acc_align_q | m_err_align;
                        i_err_bus_d   = acc_bus_q | m_err_bus;
                        if (m_rnw_q) begin
                            i_rdata_d = m_rdata;
                        end else begin
                            i_rdata_d = i_rdata_q;
                        end
                    end
                end else begin
                    acc_align_d = acc_align_q | m_err_align;
                    acc_bus_d   = acc_bus_q | m_err_bus;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_D;
            pend_i_q      <= 1'b0;
            pend_d_q      <= 1'b0;
            ireq_cmd_q    <= 2'b00;
            ireq_rnw_q    <= 1'b0;
            ireq_addr_q   <= '0;
            ireq_wdata_q  <= '0;
            dreq_cmd_q    <= 2'b00;
            dreq_rnw_q    <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_wdata_q  <= '0;
            m_cmd_q       <= CMD_IDLE;
            m_rnw_q       <= 1'b0;
            m_addr_q      <= '0;
            m_wdata_q     <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_err_align_q <= 1'b0;
            i_err_bus_q   <= 1'b0;
            d_err_align_q <= 1'b0;
            d_err_bus_q   <= 1'b0;
            acc_align_q   <= 1'b0;
            acc_bus_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            pend_i_q      <= pend_i_d;
            pend_d_q      <= pend_d_d;
            ireq_cmd_q    <= ireq_cmd_d;
            ireq_rnw_q    <= ireq_rnw_d;
            ireq_addr_q   <= ireq_addr_d;
            ireq_wdata_q  <= ireq_wdata_d;
            dreq_cmd_q    <= dreq_cmd_d;
            dreq_rnw_q    <= dreq_rnw_d;
            dreq_addr_q   <= dreq_addr_d;
            dreq_wdata_q  <= dreq_wdata_d;
            m_cmd_q       <= m_cmd_d;
            m_rnw_q       <= m_rnw_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_err_align_q <= i_err_align_d;
            i_err_bus_q   <= i_err_bus_d;
            d_err_align_q <= d_err_align_d;
            d_err_bus_q   <= d_err_bus_d;
            acc_align_q   <= acc_align_d;
            acc_bus_q     <= acc_bus_d;
        end
    end

    assign m_cmd       = m_cmd_q;
    assign m_rnw       = m_rnw_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_err_align = i_err_align_q;
    assign i_err_bus   = i_err_bus_q;
    assign d_err_align = d_err_align_q;
    assign d_err_bus   = d_err_bus_q;

endmodule

// File: tb/tb_uparc_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for uparc_lsu_arbiter: a cycle-by-cycle vector table (requester
// and master inputs plus expected outputs), followed by hand-written
// sequences for tie arbitration and reset during a transfer.
// -----------------------------------------------------------------------------
module tb_uparc_lsu_arbiter;

    localparam logic [1:0]  N = 2'b00;
    localparam logic [1:0]  B = 2'b01;
    localparam logic [1:0]  H = 2'b10;
    localparam logic [1:0]  W = 2'b11;
    localparam logic [31:0] Z = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  i_cmd = 2'b00, d_cmd = 2'b00;
    logic        i_rnw = 1'b0, d_rnw = 1'b0;
    logic [31:0] i_addr = 32'h0, i_wdata = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_busy, d_busy, i_err_align, i_err_bus, d_err_align, d_err_bus;
    logic [1:0]  m_cmd;
    logic        m_rnw;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        m_busy = 1'b0, m_err_align = 1'b0, m_err_bus = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    uparc_lsu_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst),
        .i_cmd(i_cmd), .i_rnw(i_rnw), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_busy(i_busy), .i_err_align(i_err_align), .i_err_bus(i_err_bus),
        .d_cmd(d_cmd), .d_rnw(d_rnw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_busy(d_busy), .d_err_align(d_err_align), .d_err_bus(d_err_bus),
        .m_cmd(m_cmd), .m_rnw(m_rnw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_err_align(m_err_align), .m_err_bus(m_err_bus)
    );

    // Free-running clock, rising edge active.
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ic;  logic ir; logic [31:0] ia; logic [31:0] iw;
        logic [1:0]  dc;  logic dr; logic [31:0] da; logic [31:0] dw;
        logic        mb;  logic [1:0] me; logic [31:0] mr;
        logic [1:0]  emc; logic emr; logic [31:0] ema; logic [31:0] emw;
        logic        eib; logic edb; logic [31:0] eir; logic [31:0] edr;
        logic [3:0]  eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] ic, input logic ir, input logic [31:0] ia, input logic [31:0] iw,
                       input logic [1:0] dc, input logic dr, input logic [31:0] da, input logic [31:0] dw,
                       input logic mb, input logic [1:0] me, input logic [31:0] mr,
                       input logic [1:0] emc, input logic emr, input logic [31:0] ema, input logic [31:0] emw,
                       input logic eib, input logic edb, input logic [31:0] eir, input logic [31:0] edr,
                       input logic [3:0] eerr);
        vec_t v;
        v.ic = ic; v.ir = ir; v.ia = ia; v.iw = iw;
        v.dc = dc; v.dr = dr; v.da = da; v.dw = dw;
        v.mb = mb; v.me = me; v.mr = mr;
        v.emc = emc; v.emr = emr; v.ema = ema; v.emw = emw;
        v.eib = eib; v.edb = edb; v.eir = eir; v.edr = edr; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_cmd = N; d_cmd = N;
        m_busy = 1'b0; m_err_align = 1'b0; m_err_bus = 1'b0;
    endtask

    logic got_d[$];
    logic exp_d[4];
    int   left_i, left_d;

    initial begin
        // ---------------- vector table ----------------
        // Port D WORD read 0x1000, master ready in the first WAIT cycle.
        add(N,1'b0,Z,Z, W,1'b1,32'h1000,Z, 1'b0,2'b00,Z,                N,1'b0,Z,Z,                          1'b0,1'b1,Z,Z,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                W,1'b1,32'h1000,Z,                   1'b0,1'b1,Z,Z,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,32'hDEAD_BEEF,    N,1'b1,32'h1000,Z,                   1'b0,1'b1,Z,Z,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b1,32'h1000,Z,                   1'b0,1'b0,Z,32'hDEAD_BEEF,4'b0000);
        // Simultaneous I BYTE write and D HWORD read, 3 busy cycles per transfer.
        add(B,1'b0,32'h2003,32'hA5, H,1'b1,32'h3002,32'h1111_2222, 1'b0,2'b00,Z, N,1'b1,32'h1000,Z,          1'b1,1'b1,Z,32'hDEAD_BEEF,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                H,1'b1,32'h3002,32'h1111_2222,       1'b1,1'b1,Z,32'hDEAD_BEEF,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                N,1'b1,32'h3002,32'h1111_2222,       1'b1,1'b1,Z,32'hDEAD_BEEF,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                N,1'b1,32'h3002,32'h1111_2222,       1'b1,1'b1,Z,32'hDEAD_BEEF,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,32'hCAFE_0001,    N,1'b1,32'h3002,32'h1111_2222,       1'b1,1'b1,Z,32'hDEAD_BEEF,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b1,32'h3002,32'h1111_2222,       1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                B,1'b0,32'h2003,32'hA5,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                N,1'b0,32'h2003,32'hA5,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                N,1'b0,32'h2003,32'hA5,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,32'hBAD0_BAD0,    N,1'b0,32'h2003,32'hA5,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b0,32'h2003,32'hA5,              1'b0,1'b0,Z,32'hCAFE_0001,4'b0000);
        // Port D BYTE write, bus error only in the ISSUE cycle.
        add(N,1'b0,Z,Z, B,1'b0,32'h4001,32'h5A, 1'b0,2'b00,Z,            N,1'b0,32'h2003,32'hA5,              1'b0,1'b1,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b01,Z,                B,1'b0,32'h4001,32'h5A,              1'b0,1'b1,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,32'h9999_9999,    N,1'b0,32'h4001,32'h5A,              1'b0,1'b1,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b0,32'h4001,32'h5A,              1'b0,1'b0,Z,32'hCAFE_0001,4'b0001);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b0,32'h4001,32'h5A,              1'b0,1'b0,Z,32'hCAFE_0001,4'b0000);
        // Port I WORD read, alignment error in a busy WAIT cycle.
        add(W,1'b1,32'h5000,32'h77, N,1'b0,Z,Z, 1'b0,2'b00,Z,            N,1'b0,32'h4001,32'h5A,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b00,Z,                W,1'b1,32'h5000,32'h77,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b1,2'b10,Z,                N,1'b1,32'h5000,32'h77,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,32'h1234_5678,    N,1'b1,32'h5000,32'h77,              1'b1,1'b0,Z,32'hCAFE_0001,4'b0000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b1,32'h5000,32'h77,              1'b0,1'b0,32'h1234_5678,32'hCAFE_0001,4'b1000);
        add(N,1'b0,Z,Z, N,1'b0,Z,Z,         1'b0,2'b00,Z,                N,1'b1,32'h5000,32'h77,              1'b0,1'b0,32'h1234_5678,32'hCAFE_0001,4'b0000);

        // ---------------- reset state ----------------
        #12;
        chk("rst m_cmd", {30'h0, m_cmd}, Z);
        chk("rst m_rnw", {31'h0, m_rnw}, Z);
        chk("rst m_addr", m_addr, Z);
        chk("rst m_wdata", m_wdata, Z);
        chk("rst i_rdata", i_rdata, Z);
        chk("rst d_rdata", d_rdata, Z);
        chk("rst busy", {30'h0, i_busy, d_busy}, Z);
        chk("rst err", {28'h0, i_err_align, i_err_bus, d_err_align, d_err_bus}, Z);
        @(negedge clk);
        nrst = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            i_cmd = vecs[k].ic; i_rnw = vecs[k].ir; i_addr = vecs[k].ia; i_wdata = vecs[k].iw;
            d_cmd = vecs[k].dc; d_rnw = vecs[k].dr; d_addr = vecs[k].da; d_wdata = vecs[k].dw;
            m_busy = vecs[k].mb; m_err_align = vecs[k].me[1]; m_err_bus = vecs[k].me[0];
            m_rdata = vecs[k].mr;
            @(negedge clk);
            chk($sformatf("v%0d m_cmd", k), {30'h0, m_cmd}, {30'h0, vecs[k].emc});
            chk($sformatf("v%0d m_rnw", k), {31'h0, m_rnw}, {31'h0, vecs[k].emr});
            chk($sformatf("v%0d m_addr", k), m_addr, vecs[k].ema);
            chk($sformatf("v%0d m_wdata", k), m_wdata, vecs[k].emw);
            chk($sformatf("v%0d i_busy", k), {31'h0, i_busy}, {31'h0, vecs[k].eib});
            chk($sformatf("v%0d d_busy", k), {31'h0, d_busy}, {31'h0, vecs[k].edb});
            chk($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].eir);
            chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].edr);
            chk($sformatf("v%0d err", k), {28'h0, i_err_align, i_err_bus, d_err_align, d_err_bus},
                {28'h0, vecs[k].eerr});
        end

        // ---------------- tie arbitration ----------------
        // Each port issues two WORD reads; a port re-requests as soon as it
        // is free, so ties recur while the other port is still pending.
`ifdef UPARC_LSU_ARB_RR_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b0;
`endif
        left_i = 2; left_d = 2;
        m_rdata = 32'h5555_AAAA;
        for (int cyc = 0; cyc < 60 && got_d.size() < 4; cyc++) begin
            @(posedge clk); #1;
            idle_inputs();
            i_rnw = 1'b1; d_rnw = 1'b1;
            #1;
            if (!i_busy && left_i > 0) begin
                i_cmd = W; i_addr = 32'h1000_0000 + 32'(left_i); left_i--;
            end
            if (!d_busy && left_d > 0) begin
                d_cmd = W; d_addr = 32'hD000_0000 + 32'(left_d); left_d--;
            end
            @(negedge clk);
            if (m_cmd != N) got_d.push_back(m_addr[31:28] == 4'hD);
        end
        chk("tie grant count", 32'(got_d.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_d.size(); k++) begin
            chk($sformatf("tie grant %0d is D", k), {31'h0, got_d[k]}, {31'h0, exp_d[k]});
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            idle_inputs();
        end
        @(negedge clk);
        chk("tie i_rdata", i_rdata, 32'h5555_AAAA);
        chk("tie d_rdata", d_rdata, 32'h5555_AAAA);

        // ---------------- reset during WAIT ----------------
        @(posedge clk); #1;
        i_cmd = W; i_rnw = 1'b1; i_addr = 32'h6000; i_wdata = 32'h66;
        @(posedge clk); #1;
        i_cmd = N; m_busy = 1'b1;
        @(negedge clk);
        chk("pre-rst issue", {30'h0, m_cmd}, {30'h0, W});
        @(posedge clk); #1;
        m_err_align = 1'b1; m_err_bus = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        chk("mid-rst m_cmd", {30'h0, m_cmd}, Z);
        chk("mid-rst m_rnw", {31'h0, m_rnw}, Z);
        chk("mid-rst m_addr", m_addr, Z);
        chk("mid-rst m_wdata", m_wdata, Z);
        chk("mid-rst i_rdata", i_rdata, Z);
        chk("mid-rst d_rdata", d_rdata, Z);
        chk("mid-rst busy", {30'h0, i_busy, d_busy}, Z);
        @(negedge clk);
        nrst = 1'b1;
        idle_inputs();
        m_rdata = 32'h7777_7777;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("post-rst c%0d m_cmd", k), {30'h0, m_cmd}, Z);
            chk($sformatf("post-rst c%0d i_busy", k), {31'h0, i_busy}, Z);
            chk($sformatf("post-rst c%0d i_rdata", k), i_rdata, Z);
            chk($sformatf("post-rst c%0d err", k),
                {28'h0, i_err_align, i_err_bus, d_err_align, d_err_bus}, Z);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uparc_lsu_arbiter.md
Name: uparc_lsu_arbiter

Overview:
Two-requester arbiter that shares one load/store unit (LSU) port between the instruction fetch stage (port I) and the memory access stage (port D).
- Each requester sees an LSU-style slave interface: one-cycle command, combinational busy, held read data.
- The arbiter captures each request, grants one at a time, replays the command on the master LSU port and routes completion data and errors back to the owning requester.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
i_cmd  in  2  port I command: 00 IDLE, 01 BYTE, 10 HWORD, 11 WORD
i_rnw  in  1  port I read(1)/write(0)
i_addr  in  ADDR_WIDTH  port I address
i_wdata  in  DATA_WIDTH  port I write data
i_rdata  out  DATA_WIDTH  port I read data
i_busy  out  1  port I busy/stall
i_err_align  out  1  port I alignment error pulse
i_err_bus  out  1  port I bus error pulse
d_cmd, d_rnw, d_addr, d_wdata, d_rdata, d_busy, d_err_align, d_err_bus  same directions, widths and meanings as the port I signals, for port D
m_cmd  out  2  master command
m_rnw  out  1  master read/write
m_addr  out  ADDR_WIDTH  master address
m_wdata  out  DATA_WIDTH  master write data
m_rdata  in  DATA_WIDTH  master read data
m_busy  in  1  master busy
m_err_align  in  1  master alignment error
m_err_bus  in  1  master bus error

Behaviour:
Requester side:
- A command is any cycle with x_cmd != IDLE. It is held for exactly one cycle.
- x_busy = pend_x | (x_cmd != IDLE), combinational.
- On a command, cmd/rnw/addr/wdata are latched into a per-port request register and pend_x is set.
- A command on a port with pend_x already set is a protocol violation and is ignored.

FSM states: IDLE, ISSUE, WAIT.
- IDLE: candidates are ports with pend_x or an incoming command.
  - Grant is registered as owner.
  - Request fields come from the incoming signals or the latched register, whichever applies.
  - Next state is ISSUE. With no candidates, stay in IDLE.
- ISSUE: drive m_cmd/m_rnw/m_addr/m_wdata from the owner's request for exactly one cycle, then go to WAIT.
  - m_cmd = IDLE in every other state.
  - m_addr/m_wdata/m_rnw hold their last values.
- WAIT: on the first cycle with m_busy = 0, complete:
  - if the owner's rnw = 1, register m_rdata into the owner's x_rdata;
  - clear the owner's pend_x;
  - go to IDLE.
- Errors: m_err_align and m_err_bus are OR-accumulated from ISSUE through the completion cycle. They are delivered on the owner's x_err_* as a one-cycle registered pulse in the cycle after completion, then cleared.
- Minimum latency: command in cycle 0, ISSUE in cycle 1, WAIT in cycle 2. If m_busy = 0 in cycle 2, x_busy = 0 and x_rdata is valid in cycle 3.
- x_rdata holds until that port's next read completion.
- Tie (both ports are candidates in IDLE): port D wins; port I stays pending.
- A port I command arriving while port D owns the master is captured, and the arbiter grants it on return to IDLE.
- Reset values:
  - state IDLE, owner D, pend_x 0, request registers 0;
  - m_cmd IDLE, m_rnw 0, m_addr 0, m_wdata 0;
  - x_rdata 0, x_err_* 0;
  - round-robin pointer "last granted" = I.
- Reset mid-transaction: everything returns to the reset values. In-flight requests are dropped and no pulses are emitted.
- Write data and addresses pass through unmodified. Alignment checking belongs to the downstream LSU.

Optional Feature:
UPARC_LSU_ARB_RR_EN
- Defined: on a tie the port not granted last wins. "last granted" updates at every grant.
- Undefined: fixed priority, port D always wins. The pointer logic is absent.

Test Plan:
- Port D read WORD at 0x0000_1000, m_busy low in cycle 2, m_rdata=0xDEAD_BEEF -> m_cmd=11 in cycle 1 only; d_busy 1 in cycles 0-2, 0 in cycle 3; d_rdata=0xDEAD_BEEF.
- Port I and port D command in the same cycle, m_busy 3 cycles per transfer -> D issued first, I issued in the next IDLE→ISSUE sequence. i_busy stays high throughout; I's addr/wdata are replayed unchanged from the latched register.
- Port D BYTE write with m_err_bus asserted in the ISSUE cycle only -> d_err_bus a single pulse in the cycle after completion; i_err_* stay 0; d_rdata unchanged.
- Port I command, then reset asserted during WAIT -> all outputs at reset values; after release no completion or error pulse is seen on port I.
- With UPARC_LSU_ARB_RR_EN, four back-to-back simultaneous I and D requests -> grant order D, I, D, I. Without it -> D always wins each tie.
